// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int unsigned RET_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic             trap;
    logic [RET_W-1:0] retired;

    modport master (
        input  run, opcode, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, retired
    );

    modport slave (
        output run, opcode, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, trap, retired
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RISC-V datapath: fetch/decode/execute sequencing,
// memory ready/valid handshake with watchdog, sticky trap and retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned RET_W   = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    multicycle_ctrl_if.master bus
);
    localparam int unsigned     CntW     = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(TIMEOUT - 1);

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StRExec,
        StRWb,
        StBranch,
        StTrap
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  wait_q;
    logic [RET_W-1:0] retired_q;
    logic             trap_q;
    logic             waiting;
    logic             timeout_hit;
    logic             retire;

    // Moore decode; FETCH additionally qualifies on run and mem_ready.
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.iord          = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.reg_write     = 1'b0;
        bus.mem_to_reg    = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (bus.run) begin
                    bus.mem_req   = 1'b1;
                    bus.alu_src_b = 2'b01;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_write  = bus.mem_ready;
                end
            end
            StDecode: bus.alu_src_b = 2'b10;
            StMemAddr: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            StMemRd: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            StMemWb: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            StMemWr: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            StRExec: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            StRWb: begin
                bus.reg_write = 1'b1;
                bus.alu_op    = 2'b10;
            end
            StBranch: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
            end
            default: ;
        endcase
    end

    assign waiting     = bus.mem_req && !bus.mem_ready;
    // The wait that would bring the counter to TIMEOUT is the one that traps.
    assign timeout_hit = waiting && (wait_q == WaitLast);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (bus.run) begin
                    if (bus.mem_ready)   state_d = StDecode;
                    else if (timeout_hit) state_d = StTrap;
                end
            end
            StDecode: begin
                case (bus.opcode)
                    OpLoad, OpStore: state_d = StMemAddr;
                    OpR:             state_d = StRExec;
                    OpBranch:        state_d = StBranch;
                    default:         state_d = StTrap;
                endcase
            end
            StMemAddr: state_d = (bus.opcode == OpStore) ? StMemWr : StMemRd;
            StMemRd: begin
                if (bus.mem_ready)    state_d = StMemWb;
                else if (timeout_hit) state_d = StTrap;
            end
            StMemWr: begin
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = StTrap;
                end
            end
            StMemWb, StRWb, StBranch: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StRExec: state_d = StRWb;
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            wait_q    <= '0;
            retired_q <= '0;
            trap_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_q <= '0;
            end else if (waiting) begin
                wait_q <= wait_q + CntW'(1);
            end
            if (retire) begin
                retired_q <= retired_q + RET_W'(1);
            end
            if (state_d == StTrap) begin
                trap_q <= 1'b1;
            end
        end
    end

    assign bus.trap    = trap_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-step reference model compared every cycle,
// directed scenarios with literal expectations, then randomized instruction streams.
module tb_multicycle_ctrl;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned RET_W   = 2;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b1111111;

    localparam int C_R = 0, C_L = 1, C_S = 2, C_B = 3, C_ILL = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Model: instruction class, step index within it, wait count, trapped flag, retired count.
    int m_cls, m_stp, m_wc, m_ret;
    bit m_tr;

    multicycle_ctrl_if #(.RET_W(RET_W)) bus ();

    multicycle_ctrl #(
        .TIMEOUT(TIMEOUT),
        .RET_W  (RET_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [6:0] op);
        case (op)
            OP_R:    return C_R;
            OP_L:    return C_L;
            OP_S:    return C_S;
            OP_B:    return C_B;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int last_step(input int cls);
        case (cls)
            C_R:     return 3;
            C_L:     return 4;
            C_S:     return 3;
            default: return 2;
        endcase
    endfunction

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, src_a, src_b, alu_op, rw, m2r}
    function automatic logic [12:0] exp_ctrl();
        logic req = 0, we = 0, iord = 0, irw = 0, pcw = 0, pcc = 0, a = 0, rw = 0, m2r = 0;
        logic [1:0] b = 2'b00, op = 2'b00;
        if (!m_tr) begin
            if (m_stp == 0) begin
                if (bus.run) begin
                    req = 1; b = 2'b01; irw = bus.mem_ready; pcw = bus.mem_ready;
                end
            end else if (m_stp == 1) begin
                b = 2'b10;
            end else begin
                case (m_cls)
                    C_R: begin
                        op = 2'b10;
                        if (m_stp == 2) a = 1;
                        else rw = 1;
                    end
                    C_L, C_S: begin
                        if (m_stp == 2) begin
                            a = 1; b = 2'b10;
                        end else if (m_stp == 3) begin
                            req = 1; iord = 1; we = (m_cls == C_S);
                        end else begin
                            rw = 1; m2r = 1;
                        end
                    end
                    default: begin
                        a = 1; op = 2'b01; pcc = 1;
                    end
                endcase
            end
        end
        return {req, we, iord, irw, pcw, pcc, a, b, op, rw, m2r};
    endfunction

    function automatic logic [12:0] act_ctrl();
        return {bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_write_cond, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.mem_to_reg};
    endfunction

    task automatic model_reset();
        m_cls = C_R; m_stp = 0; m_wc = 0; m_ret = 0; m_tr = 0;
    endtask

    task automatic retire();
        m_ret = (m_ret + 1) % (1 << RET_W);
        m_stp = 0;
        m_wc  = 0;
    endtask

    task automatic mem_wait();
        m_wc++;
        if (m_wc >= TIMEOUT) m_tr = 1;
    endtask

    task automatic model_update();
        if (m_tr) return;
        if (m_stp == 0) begin
            if (bus.run) begin
                if (bus.mem_ready) begin
                    m_stp = 1; m_wc = 0;
                end else begin
                    mem_wait();
                end
            end
        end else if (m_stp == 1) begin
            m_cls = classify(bus.opcode);
            if (m_cls == C_ILL) m_tr = 1;
            else m_stp = 2;
        end else if (m_stp == 3 && (m_cls == C_L || m_cls == C_S)) begin
            if (bus.mem_ready) begin
                m_wc = 0;
                if (m_cls == C_S) retire();
                else m_stp = 4;
            end else begin
                mem_wait();
            end
        end else if (m_stp == last_step(m_cls)) begin
            retire();
        end else begin
            m_stp++;
        end
    endtask

    task automatic compare_model();
        check("ctrl", 32'(act_ctrl()), 32'(exp_ctrl()));
        check("trap", 32'(bus.trap), 32'(m_tr));
        check("retired", 32'(bus.retired), m_ret);
    endtask

    task automatic drv(input logic r, input logic [6:0] o, input logic z, input logic m);
        @(negedge clk);
        bus.run = r; bus.opcode = o; bus.zero = z; bus.mem_ready = m;
        #1;
        compare_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
    endtask

    task automatic cyc(input logic r, input logic [6:0] o, input logic z, input logic m);
        drv(r, o, z, m);
        adv();
    endtask

    task automatic apply_reset();
        #2;
        rst_n   = 1'b0;
        bus.run = 1'b0;
        #1;
        model_reset();
        compare_model();
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_iord", 32'(bus.iord), 0);
        check("rst_retired", 32'(bus.retired), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [6:0] opc;
        int         pct;
        rst_n = 1'b0;
        bus.run = 0; bus.opcode = '0; bus.zero = 0; bus.mem_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        apply_reset();

        // Idle with run low: nothing happens even with mem_ready toggling.
        for (int i = 0; i < 6; i++) begin
            drv(0, OP_R, 0, 1'(i));
            check("idle_ctrl", 32'(act_ctrl()), 0);
            adv();
        end

        // R-type, zero-wait memory.
        drv(1, OP_R, 0, 1); check("r_irw", 32'(bus.ir_write), 1); adv();
        drv(1, OP_R, 0, 1); check("r_dec_srcb", 32'(bus.alu_src_b), 2); adv();
        drv(1, OP_R, 0, 1); check("r_ex_op", 32'(bus.alu_op), 2); adv();
        drv(1, OP_R, 0, 1); check("r_wb_op", 32'(bus.alu_op), 2);
        check("r_wb_rw", 32'(bus.reg_write), 1); adv();
        drv(0, OP_R, 0, 1); check("r_retired", 32'(bus.retired), 1); adv();

        // Load with three wait states in MEM_RD: 8 cycles total.
        cyc(1, OP_L, 0, 1);
        cyc(1, OP_L, 0, 0);
        cyc(1, OP_L, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, OP_L, 0, 0); check("ld_wait_req_iord", {bus.mem_req, bus.iord}, 3); adv();
        end
        drv(1, OP_L, 0, 1); check("ld_rd_req_iord", {bus.mem_req, bus.iord}, 3); adv();
        drv(1, OP_L, 0, 0); check("ld_wb", {bus.reg_write, bus.mem_to_reg}, 3); adv();
        drv(0, OP_L, 0, 0); check("ld_retired", 32'(bus.retired), 2); adv();

        // Store then branch from reset.
        apply_reset();
        cyc(1, OP_S, 0, 1);
        drv(1, OP_S, 0, 1); check("st_dec_we", 32'(bus.mem_we), 0); adv();
        cyc(1, OP_S, 0, 1);
        drv(1, OP_S, 0, 1); check("st_wr_we", 32'(bus.mem_we), 1); adv();
        cyc(1, OP_B, 1, 1);
        cyc(1, OP_B, 1, 1);
        drv(1, OP_B, 1, 1); check("br_pcc_op", {bus.pc_write_cond, bus.alu_op}, 3'b101); adv();
        drv(0, OP_B, 1, 1); check("st_br_retired", 32'(bus.retired), 2); adv();

        // Four branches wrap the 2-bit counter.
        apply_reset();
        for (int n = 0; n < 4; n++) begin
            cyc(1, OP_B, 0, 1); cyc(1, OP_B, 0, 1); cyc(1, OP_B, 0, 1);
        end
        drv(0, OP_B, 0, 0); check("wrap_retired", 32'(bus.retired), 0); adv();

        // Fetch timeout: four unanswered request cycles trap.
        apply_reset();
        for (int i = 0; i < 4; i++) cyc(1, OP_R, 0, 0);
        drv(1, OP_R, 0, 0); check("to_trap", {bus.trap, bus.mem_req}, 2'b10); adv();

        // Ready on the fourth request cycle is still a success.
        apply_reset();
        for (int i = 0; i < 3; i++) cyc(1, OP_R, 0, 0);
        cyc(1, OP_R, 0, 1);
        drv(1, OP_R, 0, 0); check("to_edge", {bus.trap, bus.alu_src_b}, 3'b010); adv();

        // Illegal opcode after one retired instruction.
        apply_reset();
        for (int i = 0; i < 4; i++) cyc(1, OP_R, 0, 1);
        cyc(1, OP_ILL, 0, 1);
        cyc(1, OP_ILL, 0, 1);
        for (int i = 0; i < 20; i++) begin
            drv(1'($urandom), 7'($urandom), 1'($urandom), 1'($urandom));
            check("ill_trap_ret", {bus.trap, bus.retired}, 3'b101); adv();
        end

        // Asynchronous reset in the middle of a load's MEM_RD.
        apply_reset();
        for (int i = 0; i < 4; i++) cyc(1, OP_R, 0, 1);
        cyc(1, OP_L, 0, 1); cyc(1, OP_L, 0, 1); cyc(1, OP_L, 0, 1);
        drv(1, OP_L, 0, 0); check("mid_rd_req", 32'(bus.mem_req), 1);
        apply_reset();

        // Randomized instruction streams.
        for (int rd = 0; rd < 6; rd++) begin
            pct = (rd % 3 == 0) ? 95 : ((rd % 3 == 1) ? 70 : 45);
            apply_reset();
            opc = OP_R;
            for (int i = 0; i < 300; i++) begin
                if (m_stp == 0) begin
                    case ($urandom_range(0, 39))
                        0:             opc = 7'($urandom);
                        1, 2, 3:       opc = OP_ILL;
                        4, 5, 6, 7, 8, 9, 10, 11, 12: opc = OP_L;
                        13, 14, 15, 16, 17, 18, 19, 20, 21: opc = OP_S;
                        22, 23, 24, 25, 26, 27, 28, 29, 30: opc = OP_B;
                        default:       opc = OP_R;
                    endcase
                end
                cyc(1'($urandom_range(0, 3) != 0), opc, 1'($urandom),
                    1'($urandom_range(0, 99) < pct));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
